// File: rtl/rf_wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Optional build macro used by the top: RF_WB_PERF_CNT_EN.
package rf_wb_pkg;

  localparam int RF_ADDR_W    = 5;
  localparam int RF_DATA_W    = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    MEM_PRI = 1'b0,
    ALU_PRI = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

  // Priority pick: the favoured requester wins when both are valid.
  function automatic grant_e pick_grant(input logic alu_pri,
                                        input logic alu_valid,
                                        input logic mem_valid);
    grant_e g;
    g = GNT_NONE;
    if (alu_pri) begin
      if (alu_valid)      g = GNT_ALU;
      else if (mem_valid) g = GNT_MEM;
    end else begin
      if (mem_valid)      g = GNT_MEM;
      else if (alu_valid) g = GNT_ALU;
    end
    return g;
  endfunction

endpackage

// File: rtl/rf_wb_starve_ctr.sv
// Starvation tracker: counts denied ALU cycles and flips the arbiter into
// ALU priority once the limit is reached, until the ALU is served or gives up.
module rf_wb_starve_ctr
  import rf_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_alu_valid,
  input  logic i_alu_grant,
  input  logic i_hold,
  output logic o_alu_pri
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT   = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] CNT_ONE = STARVE_CNT_W'(1);

  arb_state_e              r_state;
  logic [STARVE_CNT_W-1:0] r_cnt;
  logic [STARVE_CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = (r_cnt == {STARVE_CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= MEM_PRI;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MEM_PRI: begin
          if (i_alu_grant) begin
            r_cnt <= '0;
          end else if (i_alu_valid && !i_hold) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= LIMIT) r_state <= ALU_PRI;
          end
        end
        ALU_PRI: begin
          // Leaving on a withdrawn request also clears the count so the
          // next starvation episode starts from zero.
          if (i_alu_grant || !i_alu_valid) begin
            r_state <= MEM_PRI;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= MEM_PRI;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_alu_pri = (r_state == ALU_PRI);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter for the register file's single write port.
// Define RF_WB_PERF_CNT_EN to add the saturating o_conflict_cnt output.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_alu_valid,
  output logic                 o_alu_ready,
  input  logic [RF_ADDR_W-1:0] i_alu_waddr,
  input  logic [RF_DATA_W-1:0] i_alu_wdata,
  input  logic                 i_mem_valid,
  output logic                 o_mem_ready,
  input  logic [RF_ADDR_W-1:0] i_mem_waddr,
  input  logic [RF_DATA_W-1:0] i_mem_wdata,
  input  logic                 i_hold,
  output logic                 o_rd_wen,
  output logic [RF_ADDR_W-1:0] o_rd_waddr,
  output logic [RF_DATA_W-1:0] o_rd_wdata,
  output logic                 o_starved
`ifdef RF_WB_PERF_CNT_EN
  ,
  output logic [15:0]          o_conflict_cnt
`endif
);

  grant_e               w_gnt;
  logic                 w_alu_pri;
  logic [RF_ADDR_W-1:0] w_sel_waddr;
  logic [RF_DATA_W-1:0] w_sel_wdata;

  logic                 r_rd_wen;
  logic [RF_ADDR_W-1:0] r_rd_waddr;
  logic [RF_DATA_W-1:0] r_rd_wdata;

  // No grant while in reset or stalled, so no handshake can complete then.
  always_comb begin
    w_gnt = GNT_NONE;
    if (!i_rst && !i_hold) w_gnt = pick_grant(w_alu_pri, i_alu_valid, i_mem_valid);
  end

  assign o_alu_ready = (w_gnt == GNT_ALU);
  assign o_mem_ready = (w_gnt == GNT_MEM);

  always_comb begin
    w_sel_waddr = i_mem_waddr;
    w_sel_wdata = i_mem_wdata;
    if (w_gnt == GNT_ALU) begin
      w_sel_waddr = i_alu_waddr;
      w_sel_wdata = i_alu_wdata;
    end
  end

  rf_wb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_alu_valid(i_alu_valid),
    .i_alu_grant(o_alu_ready),
    .i_hold     (i_hold),
    .o_alu_pri  (w_alu_pri)
  );

  // Output stage: x0 writes complete the handshake but never assert the enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_wen   <= 1'b0;
      r_rd_waddr <= '0;
      r_rd_wdata <= '0;
    end else if (!i_hold) begin
      if (w_gnt == GNT_NONE) begin
        r_rd_wen <= 1'b0;
      end else begin
        r_rd_wen   <= (w_sel_waddr != '0);
        r_rd_waddr <= w_sel_waddr;
        r_rd_wdata <= w_sel_wdata;
      end
    end
  end

  assign o_rd_wen   = r_rd_wen;
  assign o_rd_waddr = r_rd_waddr;
  assign o_rd_wdata = r_rd_wdata;
  assign o_starved  = w_alu_pri;

`ifdef RF_WB_PERF_CNT_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_conflict_cnt <= '0;
    end else if (i_alu_valid && i_mem_valid && !i_hold && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Table-driven bench for rf_wb_arbiter with a queue of expected output-stage
// values pushed at drive time and popped once the clock edge has taken effect.
module tb_rf_wb_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_alu_valid;
  logic        o_alu_ready;
  logic [4:0]  i_alu_waddr;
  logic [31:0] i_alu_wdata;
  logic        i_mem_valid;
  logic        o_mem_ready;
  logic [4:0]  i_mem_waddr;
  logic [31:0] i_mem_wdata;
  logic        i_hold;
  logic        o_rd_wen;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata;
  logic        o_starved;
`ifdef RF_WB_PERF_CNT_EN
  logic [15:0] o_conflict_cnt;
`endif

  rf_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_alu_valid(i_alu_valid),
    .o_alu_ready(o_alu_ready),
    .i_alu_waddr(i_alu_waddr),
    .i_alu_wdata(i_alu_wdata),
    .i_mem_valid(i_mem_valid),
    .o_mem_ready(o_mem_ready),
    .i_mem_waddr(i_mem_waddr),
    .i_mem_wdata(i_mem_wdata),
    .i_hold     (i_hold),
    .o_rd_wen   (o_rd_wen),
    .o_rd_waddr (o_rd_waddr),
    .o_rd_wdata (o_rd_wdata),
    .o_starved  (o_starved)
`ifdef RF_WB_PERF_CNT_EN
    ,
    .o_conflict_cnt(o_conflict_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic        hold;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        e_ar;
    logic        e_mr;
    logic        e_st;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  a;
    logic [31:0] d;
  } out_t;

  localparam int NV = 26;
  vec_t  tbl [NV];
  out_t  sb_q [$];
  out_t  last_exp;
  logic [31:0] rf_dut [32];
  int    n_checks;
  int    n_err;

  function automatic vec_t mk(input logic rst, input logic hold,
                              input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic e_ar, input logic e_mr, input logic e_st);
    vec_t v;
    v.rst = rst; v.hold = hold;
    v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv; v.ma = ma; v.md = md;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_row(input int idx, input vec_t v);
    out_t e;
    out_t got;
    i_rst       = v.rst;
    i_hold      = v.hold;
    i_alu_valid = v.av;
    i_alu_waddr = v.aa;
    i_alu_wdata = v.ad;
    i_mem_valid = v.mv;
    i_mem_waddr = v.ma;
    i_mem_wdata = v.md;
    #1;
    chk($sformatf("row%0d alu_ready", idx), {31'd0, o_alu_ready}, {31'd0, v.e_ar});
    chk($sformatf("row%0d mem_ready", idx), {31'd0, o_mem_ready}, {31'd0, v.e_mr});
    chk($sformatf("row%0d starved", idx),   {31'd0, o_starved},   {31'd0, v.e_st});

    if (v.rst) begin
      e.wen = 1'b0; e.a = '0; e.d = '0;
    end else if (v.hold) begin
      e = last_exp;
    end else if (v.e_ar) begin
      e.wen = (v.aa != 5'd0); e.a = v.aa; e.d = v.ad;
    end else if (v.e_mr) begin
      e.wen = (v.ma != 5'd0); e.a = v.ma; e.d = v.md;
    end else begin
      e = last_exp;
      e.wen = 1'b0;
    end
    sb_q.push_back(e);
    last_exp = e;

    @(posedge i_clk);
    @(negedge i_clk);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL row%0d scoreboard: got empty queue expected one entry", idx);
    end else begin
      got = sb_q.pop_front();
      chk($sformatf("row%0d rd_wen", idx),   {31'd0, o_rd_wen}, {31'd0, got.wen});
      chk($sformatf("row%0d rd_waddr", idx), {27'd0, o_rd_waddr}, {27'd0, got.a});
      chk($sformatf("row%0d rd_wdata", idx), o_rd_wdata, got.d);
    end
    if (o_rd_wen) rf_dut[o_rd_waddr] = o_rd_wdata;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    for (int i = 0; i < 32; i++) rf_dut[i] = '0;
    last_exp.wen = 1'b0; last_exp.a = '0; last_exp.d = '0;

    //            rst hold av aa     ad            mv ma     md            ar mr st
    tbl[0]  = mk(1, 0, 1, 5'd1,  32'd11,        1, 5'd2,  32'd22,        0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 5'd1,  32'd11,        1, 5'd2,  32'd22,        0, 1, 0);
    tbl[2]  = mk(0, 0, 1, 5'd5,  32'hDEADBEEF,  0, 5'd0,  32'd0,         1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,         0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 5'd7,  32'd77,        1, 5'd10, 32'd100,       0, 1, 0);
    tbl[5]  = mk(0, 0, 1, 5'd7,  32'd77,        1, 5'd11, 32'd101,       0, 1, 0);
    tbl[6]  = mk(0, 0, 1, 5'd7,  32'd77,        1, 5'd12, 32'd102,       0, 1, 0);
    tbl[7]  = mk(0, 0, 1, 5'd7,  32'd77,        1, 5'd12, 32'd102,       1, 0, 1);
    tbl[8]  = mk(0, 0, 1, 5'd7,  32'd78,        1, 5'd13, 32'd103,       0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 5'd0,  32'd0,         1, 5'd0,  32'h1234,      0, 1, 0);
    tbl[10] = mk(0, 0, 1, 5'd9,  32'hA5A5A5A5,  0, 5'd0,  32'd0,         1, 0, 0);
    tbl[11] = mk(0, 1, 1, 5'd4,  32'd44,        1, 5'd14, 32'd104,       0, 0, 0);
    tbl[12] = mk(0, 1, 1, 5'd4,  32'd44,        1, 5'd14, 32'd104,       0, 0, 0);
    tbl[13] = mk(0, 1, 1, 5'd4,  32'd44,        1, 5'd14, 32'd104,       0, 0, 0);
    tbl[14] = mk(0, 0, 1, 5'd4,  32'd44,        1, 5'd14, 32'd104,       0, 1, 0);
    tbl[15] = mk(0, 0, 1, 5'd4,  32'd44,        0, 5'd0,  32'd0,         1, 0, 0);
    tbl[16] = mk(0, 0, 1, 5'd3,  32'h2,         1, 5'd3,  32'h1,         0, 1, 0);
    tbl[17] = mk(0, 0, 1, 5'd3,  32'h2,         0, 5'd0,  32'd0,         1, 0, 0);
    tbl[18] = mk(0, 0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,         0, 0, 0);
    tbl[19] = mk(0, 0, 1, 5'd8,  32'd88,        1, 5'd15, 32'd105,       0, 1, 0);
    tbl[20] = mk(0, 0, 1, 5'd8,  32'd88,        1, 5'd16, 32'd106,       0, 1, 0);
    tbl[21] = mk(0, 0, 1, 5'd8,  32'd88,        1, 5'd17, 32'd107,       0, 1, 0);
    tbl[22] = mk(0, 0, 0, 5'd8,  32'd88,        1, 5'd18, 32'd108,       0, 1, 1);
    tbl[23] = mk(0, 0, 1, 5'd8,  32'd88,        1, 5'd19, 32'd109,       0, 1, 0);
    tbl[24] = mk(1, 0, 1, 5'd8,  32'd88,        1, 5'd20, 32'd110,       0, 0, 0);
    tbl[25] = mk(0, 0, 0, 5'd0,  32'd0,         0, 5'd0,  32'd0,         0, 0, 0);

    // First reset cycle brings the DUT to a known state before checking starts.
    i_rst = 1'b1; i_hold = 1'b0;
    i_alu_valid = 1'b1; i_alu_waddr = 5'd1; i_alu_wdata = 32'd11;
    i_mem_valid = 1'b1; i_mem_waddr = 5'd2; i_mem_wdata = 32'd22;
    @(posedge i_clk);
    @(negedge i_clk);

    for (int i = 0; i < NV; i++) apply_row(i, tbl[i]);

    // Same-address collision: mem landed first, ALU last, so x3 holds the ALU value.
    chk("collision x3 final", rf_dut[3], 32'h2);
    chk("scoreboard drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
